// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: front-panel and coin-acceptor sequencer for the washer controller.
// It debounces the raw buttons and the lid switch, and accumulates coin credit.
// It presents a held coin level, a one-hot mode level and one-cycle cancel pulses.
// Optional feature: define WM_PANEL_REFUND_EN to build the coin-refund state.
// Without that macro, cancel keeps the credit and o_refund is tied low.
module wm_panel_ctrl #(
    parameter int DEB_CYCLES = 5,
    parameter int PRICE      = 2,
    parameter int CREDIT_W   = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_coin_raw,
    input  logic                i_mode_btn_raw,
    input  logic                i_start_btn_raw,
    input  logic                i_cancel_btn_raw,
    input  logic                i_lid_raw,
    input  logic                i_ready,
    input  logic                i_idle,
    input  logic                i_done,
    output logic                o_coin,
    output logic                o_mode_1,
    output logic                o_mode_2,
    output logic                o_mode_3,
    output logic                o_cancel,
    output logic                o_lid,
    output logic [1:0]          o_sel,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_refund
);

    localparam int N_IN      = 5;
    localparam int IN_COIN   = 0;
    localparam int IN_MODE   = 1;
    localparam int IN_START  = 2;
    localparam int IN_CANCEL = 3;
    localparam int IN_LID    = 4;

    localparam int                  CNT_W      = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAID,
        ST_SELECT,
        ST_RUN,
        ST_REFUND
    } state_t;

    logic [N_IN-1:0]             raw;
    logic [N_IN-1:0]             sync1_q, sync1_d;
    logic [N_IN-1:0]             sync2_q, sync2_d;
    logic [N_IN-1:0]             deb_q, deb_d;
    logic [N_IN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]                  ev;

    state_t                      state_q, state_d;
    logic [CREDIT_W-1:0]         credit_q, credit_d;
    logic [1:0]                  sel_q, sel_d;
    logic [2:0]                  mode_q, mode_d;
    logic                        coin_q, coin_d;
    logic                        cancel_q, cancel_d;
    logic                        coin_ok;
    logic                        lid_open;
`ifdef WM_PANEL_REFUND_EN
    logic                        refund_q, refund_d;
    logic                        phase_q, phase_d;
`endif

    // Map the displayed selection (1..3) onto the one-hot mode lines.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            2'd2:    sel_onehot = 3'b010;
            2'd3:    sel_onehot = 3'b100;
            default: sel_onehot = 3'b001;
        endcase
    endfunction

    assign raw = {i_lid_raw, i_cancel_btn_raw, i_start_btn_raw, i_mode_btn_raw, i_coin_raw};

    // Two-flop synchronizers plus per-input debounce counters; events fire on the accepting edge.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        ev = deb_d[3:0] & ~deb_q[3:0];
    end

    // Input conditioning registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lid_open = deb_q[IN_LID];
    // Coins are only banked while the machine is not running or paying back.
    assign coin_ok  = ev[IN_COIN] && (state_q != ST_RUN) && (state_q != ST_REFUND);

    // Next-state, credit and registered-output logic; cancel overrides every state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        cancel_d = 1'b0;
`ifdef WM_PANEL_REFUND_EN
        refund_d = 1'b0;
        phase_d  = phase_q;
`endif
        if (coin_ok && (credit_q != CREDIT_MAX)) begin
            credit_d = credit_q + CREDIT_W'(1);
        end

        if (ev[IN_CANCEL]) begin
            cancel_d = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
`ifdef WM_PANEL_REFUND_EN
            else begin
                state_d = ST_REFUND;
                if (state_q != ST_REFUND) begin
                    phase_d = 1'b0;
                end
            end
`else
            else begin
                state_d = ST_IDLE;
            end
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((credit_q >= PRICE_C) && !lid_open) begin
                        state_d = ST_PAID;
                    end
                end
                ST_PAID: begin
                    if (i_ready) begin
                        state_d = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (ev[IN_MODE]) begin
                        sel_d = (sel_q == 2'd3) ? 2'd1 : sel_q + 2'd1;
                    end
                    // A coin landing on the start cycle is still banked (credit stays >= PRICE here).
                    if (ev[IN_START] && !lid_open) begin
                        state_d  = ST_RUN;
                        credit_d = credit_q - PRICE_C + CREDIT_W'(coin_ok);
                    end
                end
                ST_RUN: begin
                    if (i_done || i_idle) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef WM_PANEL_REFUND_EN
                ST_REFUND: begin
                    // Eject one coin every other cycle until the credit is exhausted.
                    if (credit_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (!phase_q) begin
                        refund_d = 1'b1;
                        credit_d = credit_q - CREDIT_W'(1);
                        phase_d  = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                    end
                end
`else
                ST_REFUND: state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        // Mode lines latch the selection on entry to RUN and stay frozen until it is left.
        if (state_d == ST_RUN) begin
            mode_d = (state_q == ST_RUN) ? mode_q : sel_onehot(sel_q);
        end else begin
            mode_d = 3'b000;
        end
        coin_d = (state_d == ST_PAID);
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            sel_q    <= 2'd1;
            mode_q   <= 3'b000;
            coin_q   <= 1'b0;
            cancel_q <= 1'b0;
`ifdef WM_PANEL_REFUND_EN
            refund_q <= 1'b0;
            phase_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            coin_q   <= coin_d;
            cancel_q <= cancel_d;
`ifdef WM_PANEL_REFUND_EN
            refund_q <= refund_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign o_coin   = coin_q;
    assign o_mode_1 = mode_q[0];
    assign o_mode_2 = mode_q[1];
    assign o_mode_3 = mode_q[2];
    assign o_cancel = cancel_q;
    assign o_lid    = deb_q[IN_LID];
    assign o_sel    = sel_q;
    assign o_credit = credit_q;
`ifdef WM_PANEL_REFUND_EN
    assign o_refund = refund_q;
`else
    assign o_refund = 1'b0;
`endif

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Testbench for wm_panel_ctrl (default parameters: DEB_CYCLES=5, PRICE=2, CREDIT_W=3).
// Expected values are queued when stimulus is applied and popped when the DUT output is sampled.
module tb_wm_panel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_raw, mode_raw, start_raw, cancel_raw, lid_raw;
    logic       ready, idle, done;
    logic       o_coin, o_mode_1, o_mode_2, o_mode_3, o_cancel, o_lid, o_refund;
    logic [1:0] o_sel;
    logic [2:0] o_credit;
    logic [2:0] mode_obs;
    logic [6:0] flags_obs;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total  = 0;
    int   passed = 0;

    wm_panel_ctrl #(
        .DEB_CYCLES(5),
        .PRICE     (2),
        .CREDIT_W  (3)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_coin_raw      (coin_raw),
        .i_mode_btn_raw  (mode_raw),
        .i_start_btn_raw (start_raw),
        .i_cancel_btn_raw(cancel_raw),
        .i_lid_raw       (lid_raw),
        .i_ready         (ready),
        .i_idle          (idle),
        .i_done          (done),
        .o_coin          (o_coin),
        .o_mode_1        (o_mode_1),
        .o_mode_2        (o_mode_2),
        .o_mode_3        (o_mode_3),
        .o_cancel        (o_cancel),
        .o_lid           (o_lid),
        .o_sel           (o_sel),
        .o_credit        (o_credit),
        .o_refund        (o_refund)
    );

    always #5 clk = ~clk;

    assign mode_obs  = {o_mode_3, o_mode_2, o_mode_1};
    assign flags_obs = {o_coin, o_mode_3, o_mode_2, o_mode_1, o_cancel, o_refund, o_lid};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [31:0] v);
        exp_q.push_back('{n, v});
    endtask

    function automatic exp_t pop_exp();
        exp_t r;
        if (exp_q.size() == 0) begin
            r.name = "scoreboard_empty";
            r.val  = 'x;
        end else begin
            r = exp_q.pop_front();
        end
        return r;
    endfunction

    task automatic set_raw(input int which, input logic v);
        case (which)
            0:       coin_raw   = v;
            1:       mode_raw   = v;
            2:       start_raw  = v;
            3:       cancel_raw = v;
            default: lid_raw    = v;
        endcase
    endtask

    // Hold a raw input high, release it, and wait for the release to debounce.
    task automatic press(input int which, input int hold);
        set_raw(which, 1'b1);
        tick(hold);
        set_raw(which, 1'b0);
        tick(8);
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    task automatic test_reset();
        push_exp("rst_credit", 32'd0);
        push_exp("rst_sel", 32'd1);
        push_exp("rst_flags", 32'd0);
        rst = 1'b1;
        tick(3);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_sel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_sel, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(flags_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, flags_obs, e.val[6:0]); else passed++;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_coin_debounce();
        push_exp("glitch_credit", 32'd0);
        push_exp("coin_edge6_credit", 32'd0);
        push_exp("coin_edge7_credit", 32'd1);
        push_exp("coin_one_no_pay", 32'd0);
        coin_raw = 1'b1;
        tick(3);
        coin_raw = 1'b0;
        tick(10);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        coin_raw = 1'b1;
        tick(6);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(1);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(3);
        coin_raw = 1'b0;
        tick(8);
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
    endtask

    task automatic test_payment();
        push_exp("pay_credit", 32'd2);
        push_exp("pay_coin_before", 32'd0);
        push_exp("pay_coin_paid", 32'd1);
        push_exp("pay_coin_select", 32'd0);
        coin_raw = 1'b1;
        tick(7);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
        tick(1);
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
        tick(2);
        coin_raw = 1'b0;
        tick(8);
        pulse_ready();
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
    endtask

    task automatic test_select_start();
        push_exp("sel_after_1", 32'd2);
        push_exp("sel_after_2", 32'd3);
        push_exp("lid_open", 32'd1);
        push_exp("lid_open_start_mode", 32'd0);
        push_exp("lid_open_start_credit", 32'd2);
        push_exp("lid_closed", 32'd0);
        push_exp("start_edge6_mode", 32'd0);
        push_exp("start_edge7_mode", 32'b100);
        push_exp("start_credit", 32'd0);
        push_exp("run_mode_held", 32'b100);
        push_exp("done_mode", 32'd0);
        push_exp("done_coin", 32'd0);
        press(1, 10);
        e = pop_exp(); total++;
        if (32'(o_sel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_sel, e.val); else passed++;
        press(1, 10);
        e = pop_exp(); total++;
        if (32'(o_sel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_sel, e.val); else passed++;
        lid_raw = 1'b1;
        tick(8);
        e = pop_exp(); total++;
        if (32'(o_lid) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_lid, e.val); else passed++;
        press(2, 10);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        lid_raw = 1'b0;
        tick(8);
        e = pop_exp(); total++;
        if (32'(o_lid) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_lid, e.val); else passed++;
        start_raw = 1'b1;
        tick(6);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        tick(1);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(3);
        start_raw = 1'b0;
        tick(8);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        pulse_done();
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        tick(2);
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 9; n++) begin
            push_exp($sformatf("sat_coin_%0d", n), (n > 7) ? 32'd7 : 32'(n));
            press(0, 10);
            e = pop_exp(); total++;
            if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        end
        push_exp("sat_coin_level", 32'd1);
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
    endtask

    task automatic test_cancel_run();
        push_exp("run_mode", 32'b100);
        push_exp("run_credit", 32'd5);
        push_exp("cancel_edge6", 32'd0);
        push_exp("cancel_pulse", 32'd1);
        push_exp("cancel_mode", 32'd0);
        push_exp("cancel_credit", 32'd5);
        push_exp("cancel_pulse_end", 32'd0);
        pulse_ready();
        start_raw = 1'b1;
        tick(7);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(3);
        start_raw = 1'b0;
        tick(8);
        cancel_raw = 1'b1;
        tick(6);
        e = pop_exp(); total++;
        if (32'(o_cancel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_cancel, e.val); else passed++;
        tick(1);
        e = pop_exp(); total++;
        if (32'(o_cancel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_cancel, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(1);
        e = pop_exp(); total++;
        if (32'(o_cancel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_cancel, e.val); else passed++;
        cancel_raw = 1'b0;
        tick(8);
    endtask

    task automatic test_overlap();
        push_exp("run2_credit", 32'd3);
        push_exp("run3_credit", 32'd1);
        push_exp("overlap_mode", 32'b100);
        push_exp("overlap_credit", 32'd1);
        push_exp("overlap_after_done", 32'd1);
        pulse_ready();
        press(2, 10);
        pulse_done();
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(1);
        pulse_ready();
        press(2, 10);
        pulse_done();
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        press(0, 10);
        pulse_ready();
        coin_raw  = 1'b1;
        start_raw = 1'b1;
        tick(7);
        e = pop_exp(); total++;
        if (32'(mode_obs) !== e.val) $display("FAIL %s: got %b expected %b", e.name, mode_obs, e.val[2:0]); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        tick(3);
        coin_raw  = 1'b0;
        start_raw = 1'b0;
        tick(8);
        pulse_done();
        tick(2);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
    endtask

    task automatic test_refund();
        push_exp("refund_setup_credit", 32'd3);
        push_exp("refund_cancel_pulse", 32'd1);
        push_exp("refund_cancel_coin", 32'd0);
        push_exp("refund_cancel_credit", 32'd3);
        press(0, 10);
        press(0, 10);
        pulse_ready();
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        cancel_raw = 1'b1;
        tick(7);
        e = pop_exp(); total++;
        if (32'(o_cancel) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_cancel, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
`ifdef WM_PANEL_REFUND_EN
        for (int k = 1; k <= 7; k++) begin
            push_exp($sformatf("refund_pulse_%0d", k), ((k % 2 == 1) && (k <= 5)) ? 32'd1 : 32'd0);
            push_exp($sformatf("refund_credit_%0d", k), (k <= 2) ? 32'd2 : ((k <= 4) ? 32'd1 : 32'd0));
            tick(1);
            e = pop_exp(); total++;
            if (32'(o_refund) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_refund, e.val); else passed++;
            e = pop_exp(); total++;
            if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        end
        cancel_raw = 1'b0;
        tick(8);
        push_exp("refund_idle_coin", 32'd1);
        press(0, 10);
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
`else
        push_exp("norefund_repay", 32'd1);
        push_exp("norefund_credit", 32'd3);
        push_exp("norefund_pin", 32'd0);
        tick(1);
        e = pop_exp(); total++;
        if (32'(o_coin) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_coin, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_credit) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_credit, e.val); else passed++;
        e = pop_exp(); total++;
        if (32'(o_refund) !== e.val) $display("FAIL %s: got %0d expected %0d", e.name, o_refund, e.val); else passed++;
        cancel_raw = 1'b0;
        tick(8);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        coin_raw   = 1'b0;
        mode_raw   = 1'b0;
        start_raw  = 1'b0;
        cancel_raw = 1'b0;
        lid_raw    = 1'b0;
        ready      = 1'b0;
        idle       = 1'b0;
        done       = 1'b0;
        test_reset();
        test_coin_debounce();
        test_payment();
        test_select_start();
        test_saturation();
        test_cancel_run();
        test_overlap();
        test_refund();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wm_panel_ctrl.md
# wm_panel_ctrl

Front-panel and coin-acceptor controller that drives the washing-machine controller's user inputs. It debounces raw buttons and the lid switch, and accumulates coin credit. It sequences payment, mode selection and start, presenting the controller with a held coin level, a one-hot mode level and single-cycle cancel pulses. It tracks controller status (ready/idle/done) to know when a cycle is paid for, running and finished.

## Interface
Parameters:
- DEB_CYCLES, 5: consecutive stable synchronized cycles needed to accept an input change (20 ms at 250 Hz).
- PRICE, 2: coins required per wash cycle; 1 ≤ PRICE ≤ 2^CREDIT_W−1.
- CREDIT_W, 3: credit counter width.

Ports:
- i_clk  in  1  system clock (250 Hz).
- i_rst  in  1  asynchronous, active-high reset.
- i_coin_raw  in  1  coin sensor, raw, asynchronous.
- i_mode_btn_raw  in  1  mode-select button, raw.
- i_start_btn_raw  in  1  start button, raw.
- i_cancel_btn_raw  in  1  cancel button, raw.
- i_lid_raw  in  1  lid switch, raw (1 = open).
- i_ready  in  1  controller is in READY.
- i_idle  in  1  controller is in IDLE.
- i_done  in  1  controller cycle-complete strobe.
- o_coin  out  1  coin-present level to the controller.
- o_mode_1, o_mode_2, o_mode_3  out  1 each  one-hot mode level to the controller.
- o_cancel  out  1  one-cycle cancel pulse.
- o_lid  out  1  debounced lid level.
- o_sel  out  2  displayed selection: 1, 2 or 3.
- o_credit  out  CREDIT_W  current credit.
- o_refund  out  1  coin-eject pulse (see Configuration).

## Operation
- Each raw input passes through a 2-flop synchronizer and then a debouncer.
  - The debouncer counter clears while the synchronized value s equals the debounced value d, and increments while they differ.
  - At count DEB_CYCLES−1 with s≠d, the debouncer sets d←s and clears the counter.
  - An event is a debounced rising edge, high for exactly one cycle. o_lid equals d of the lid input.
- Credit: each coin event adds 1. Credit saturates at 2^CREDIT_W−1; excess coins are lost. Coin events are ignored in RUN and REFUND.
- FSM states: IDLE, PAID, SELECT, RUN, REFUND.
  - IDLE: if credit ≥ PRICE and o_lid=0, go to PAID.
  - PAID: o_coin=1. When i_ready=1, go to SELECT (o_coin drops with the state).
  - SELECT: a mode event advances o_sel 1→2→3→1. A start event with o_lid=0 goes to RUN, registers o_mode_<o_sel>=1 and sets credit←credit−PRICE. A start event with the lid open is ignored.
  - RUN: o_mode held stable. i_done or i_idle goes to IDLE and clears o_mode.
  - Cancel event (any state, highest priority): o_cancel=1 for one cycle. From RUN, go to IDLE. Otherwise go to REFUND if the macro is defined, else IDLE.
- Simultaneous coin event and credit consumption: credit ← credit − PRICE + 1.
- o_mode_* are all 0 outside RUN, so the controller can never leave READY without a start.
- o_sel retains its value across cycles and resets to 1.

## Timing
- Reset values (asynchronous): state IDLE; credit 0; o_sel 1; o_coin, o_mode_*, o_cancel, o_refund 0; o_lid 0; synchronizers and debounced values 0.
- Raw-to-debounced latency: d updates on the (DEB_CYCLES+2)th rising edge, counting as edge 1 the first edge that samples the new raw level. A raw glitch shorter than DEB_CYCLES cycles never propagates.
- Event-to-output latency:
  - State change and the o_cancel pulse occur on the edge after the event cycle.
  - o_coin rises 1 edge after the credit reaches PRICE.
  - o_mode rises 1 edge after the start event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- WM_PANEL_REFUND_EN defined:
  - Cancel outside RUN enters REFUND.
  - In REFUND, o_refund pulses high for 1 cycle every 2 cycles, and credit decrements by 1 per pulse.
  - When credit reaches 0, the FSM returns to IDLE; if credit is 0 on entry, it returns on the next edge.
  - Coin and start events are ignored in REFUND.
- Not defined:
  - REFUND is not implemented and o_refund is tied to 0.
  - Cancel keeps the credit, and the FSM goes to IDLE.

## Test plan
- Coin debounce: a 3-cycle raw coin glitch → credit stays 0; a raw coin held 10 cycles → credit 1, with the increment on edge DEB_CYCLES+2 = 7.
- Payment: 2 coins with the lid closed → o_coin=1 in PAID; assert i_ready → SELECT, o_coin=0.
- Selection and start:
  - Mode pressed twice → o_sel=3.
  - Start with the lid open → stays in SELECT.
  - Lid closed, start → o_mode_3=1, credit 0; i_done → o_mode_*=000 and IDLE.
- Saturation and overlap:
  - 9 coins with CREDIT_W=3 → credit 7.
  - Coin event on the start cycle with credit 2 → credit 1.
- Cancel in RUN → one-cycle o_cancel, IDLE, credit unchanged.
- Refund, macro defined: credit 3, cancel in SELECT → o_cancel pulse, three o_refund pulses 2 cycles apart, credit 0, then IDLE. Macro undefined: credit remains 3 and the FSM is in IDLE.
